// File: rtl/ins_cache.sv
// Direct-mapped, one-word-per-line instruction cache. Misses are filled byte by
// byte from the memory arbiter, assembled little-endian, installed, then returned.
module ins_cache #(
    parameter int ADDR_WIDTH  = 17,
    parameter int INS_WIDTH   = 32,
    parameter int INDEX_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  flush,
    input  logic                  ins_call,
    input  logic [ADDR_WIDTH-1:0] addr_in,
    output logic                  ins_get,
    output logic [INS_WIDTH-1:0]  ins_out,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_valid,
    input  logic [7:0]            mem_byte
);
    localparam int TAG_W = ADDR_WIDTH - INDEX_WIDTH - 2;
    localparam int LINES = 1 << INDEX_WIDTH;

    typedef enum logic [1:0] {IDLE, FILL, RESP} state_t;

    state_t                  state;
    logic [LINES-1:0]        valid;
    logic [TAG_W-1:0]        tags [LINES];
    logic [INS_WIDTH-1:0]    data [LINES];
    logic [ADDR_WIDTH-1:2]   addr_q;
    logic [1:0]              k;
    logic [INS_WIDTH-1:0]    asm_q;

    logic [INDEX_WIDTH-1:0]  idx_in, idx_q;
    logic [TAG_W-1:0]        tag_in, tag_q;
    logic                    hit;
    logic                    last_byte;
    logic                    unused_bits;

    assign idx_in      = addr_in[INDEX_WIDTH+1:2];
    assign tag_in      = addr_in[ADDR_WIDTH-1:INDEX_WIDTH+2];
    assign idx_q       = addr_q[INDEX_WIDTH+1:2];
    assign tag_q       = addr_q[ADDR_WIDTH-1:INDEX_WIDTH+2];
    assign hit         = valid[idx_in] && (tags[idx_in] == tag_in);
    assign last_byte   = (state == FILL) && mem_valid && (k == 2'd3);
    assign unused_bits = ^addr_in[1:0];

    // Tag/data storage carries no reset; only the valid bits qualify it.
    always_ff @(posedge clk) begin
        if (rst && en && !flush && last_byte) begin
            tags[idx_q] <= tag_q;
            data[idx_q] <= {mem_byte, asm_q[23:0]};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            valid    <= '0;
            addr_q   <= '0;
            k        <= '0;
            asm_q    <= '0;
            ins_get  <= 1'b0;
            ins_out  <= '0;
            mem_req  <= 1'b0;
            mem_addr <= '0;
        end else if (en) begin
            ins_get <= 1'b0;
            if (flush) begin
                valid   <= '0;
                mem_req <= 1'b0;
                k       <= '0;
                state   <= IDLE;
            end else begin
                case (state)
                    IDLE: if (ins_call) begin
                        addr_q <= addr_in[ADDR_WIDTH-1:2];
                        if (hit) begin
                            ins_get <= 1'b1;
                            ins_out <= data[idx_in];
                        end else begin
                            k        <= '0;
                            mem_req  <= 1'b1;
                            mem_addr <= {addr_in[ADDR_WIDTH-1:2], 2'b00};
                            state    <= FILL;
                        end
                    end
                    FILL: if (mem_valid) begin
                        asm_q[{k, 3'b000} +: 8] <= mem_byte;
                        k <= k + 2'd1;
                        if (k != 2'd3) begin
                            mem_addr <= mem_addr + ADDR_WIDTH'(1);
                        end else begin
                            mem_req      <= 1'b0;
                            valid[idx_q] <= 1'b1;
                            state        <= RESP;
                        end
                    end
                    RESP: begin
                        ins_out <= asm_q;
                        ins_get <= 1'b1;
                        state   <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ins_cache.sv
// Directed bench for ins_cache: stimulus pushes expected {word, latency} into a
// queue; a negedge monitor pops and compares on every ins_get pulse.
module tb_ins_cache;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b1;
    logic        flush = 1'b0;
    logic        ins_call = 1'b0;
    logic [16:0] addr_in = '0;
    logic        ins_get;
    logic [31:0] ins_out;
    logic        mem_req;
    logic [16:0] mem_addr;
    logic        mem_valid;
    logic [7:0]  mem_byte;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [31:0] word;
        int          lat;
        int          t0;
    } exp_t;
    exp_t q[$];

    ins_cache dut (
        .clk(clk), .rst(rst), .en(en), .flush(flush),
        .ins_call(ins_call), .addr_in(addr_in),
        .ins_get(ins_get), .ins_out(ins_out),
        .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_valid(mem_valid), .mem_byte(mem_byte)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Arbiter model, L=1: a byte is presented the cycle after each address change.
    function automatic logic [7:0] mem_fn(input logic [16:0] a);
        case (a)
            17'h00010: return 8'h13;
            17'h00011: return 8'h05;
            17'h00012: return 8'h10;
            17'h00013: return 8'h00;
            17'h00110: return 8'h93;
            17'h00111: return 8'h00;
            17'h00112: return 8'h80;
            17'h00113: return 8'h00;
            17'h00024: return 8'hef;
            17'h00025: return 8'hbe;
            17'h00026: return 8'had;
            17'h00027: return 8'hde;
            default:   return 8'hff;
        endcase
    endfunction
    assign mem_valid = mem_req & en;
    assign mem_byte  = mem_fn(mem_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: every ins_get must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst && ins_get) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ins_get: got word %0h with no request outstanding", ins_out);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("ins_out", ins_out, e.word);
                check("latency", 32'(cyc - e.t0), 32'(e.lat));
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic call(input logic [16:0] a, input logic [31:0] w, input int lat, input bit push);
        ins_call = 1'b1;
        addr_in  = a;
        if (push) q.push_back('{word: w, lat: lat, t0: cyc});
        step();
        ins_call = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (q.size() != 0 && n < 60) begin
            step();
            n++;
        end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: %0d responses outstanding, expected 0", name, q.size());
            q.delete();
        end
    endtask

    initial begin
        step();
        step();
        check("reset_ins_get", 32'(ins_get), 32'd0);
        check("reset_ins_out", ins_out, 32'd0);
        check("reset_mem_req", 32'(mem_req), 32'd0);
        check("reset_mem_addr", 32'(mem_addr), 32'd0);
        rst = 1'b1;
        step();

        // Cold miss, then hits back-to-back
        call(17'h00010, 32'h00100513, 6, 1'b1);
        check("miss_mem_req", 32'(mem_req), 32'd1);
        check("miss_mem_addr", 32'(mem_addr), 32'h10);
        wait_done("cold_miss");
        call(17'h00010, 32'h00100513, 1, 1'b1);
        check("hit_mem_req", 32'(mem_req), 32'd0);
        wait_done("hit1");
        call(17'h00010, 32'h00100513, 1, 1'b1);
        wait_done("hit2");

        // Conflict replacement on index 4
        call(17'h00110, 32'h00800093, 6, 1'b1);
        wait_done("conflict_fill");
        call(17'h00010, 32'h00100513, 6, 1'b1);
        wait_done("conflict_refill");
        call(17'h00010, 32'h00100513, 1, 1'b1);
        wait_done("conflict_hit");

        // Flush after two bytes; a same-cycle call is dropped
        call(17'h00024, 32'h0, 0, 1'b0);
        step();
        step();
        flush    = 1'b1;
        ins_call = 1'b1;
        addr_in  = 17'h00010;
        step();
        flush    = 1'b0;
        ins_call = 1'b0;
        check("flush_mem_req", 32'(mem_req), 32'd0);
        repeat (8) step();
        call(17'h00010, 32'h00100513, 6, 1'b1);
        wait_done("post_flush_miss");

        // Stall five cycles after the first byte
        call(17'h00024, 32'hdeadbeef, 11, 1'b1);
        step();
        en = 1'b0;
        repeat (5) step();
        check("stall_mem_addr", 32'(mem_addr), 32'h25);
        check("stall_mem_req", 32'(mem_req), 32'd1);
        en = 1'b1;
        wait_done("stall");

        // Async reset mid-fill
        call(17'h00110, 32'h0, 0, 1'b0);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("rst_ins_get", 32'(ins_get), 32'd0);
        check("rst_ins_out", ins_out, 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        step();
        rst = 1'b1;
        step();
        call(17'h00110, 32'h00800093, 6, 1'b1);
        wait_done("post_rst_miss");
        call(17'h00024, 32'hdeadbeef, 6, 1'b1);
        wait_done("post_rst_miss2");

        repeat (3) step();
        check("queue_empty", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
